// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, built from two
// half-add stages and a carry flop. Optional subtract via SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_ha2_s;
  logic             w_ha2_c;
  logic             w_cout;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_init;

  // Full adder as two cascaded half-adds on the current LSBs and carry flop.
  assign w_ha1_s = r_a_sh[0] ^ r_b_sh[0];
  assign w_ha1_c = r_a_sh[0] & r_b_sh[0];
  assign w_ha2_s = w_ha1_s ^ r_c;
  assign w_ha2_c = w_ha1_s & r_c;
  assign w_cout  = w_ha1_c | w_ha2_c;

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && start;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: a + ~b + 1, so carry-out means "no borrow".
  assign w_b_load = sub ? ~b : b;
  assign w_c_init = sub;
`else
  assign w_b_load = b;
  assign w_c_init = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= w_b_load;
      r_c    <= w_c_init;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= {w_ha2_s, r_res_sh[WIDTH-1:1]};
      r_c      <= w_cout;
      if (w_last) begin
        // Publish including the final bit; counter wraps so it never passes WIDTH-1.
        r_cnt   <= '0;
        r_sum   <= {w_ha2_s, r_res_sh[WIDTH-1:1]};
        r_carry <= w_cout;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected results computed
// arithmetically, a negedge monitor pops and compares on each done strobe.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] last_sum   = '0;
  logic         last_carry = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic msub);
    int unsigned ia;
    int unsigned ib;
    int unsigned t;
    logic [W-1:0] r;
    logic c;
    ia = ma;
    ib = mb;
    if (msub) begin
      t = ia - ib;
      c = (ia >= ib);
    end else begin
      t = ia + ib;
      c = (t >= (1 << W));
    end
    r = t[W-1:0];
    return {c, r};
  endfunction

  // Monitor: compare on done, and check outputs hold while running.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 sum=%0h required no strobe", sum);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("sum", sum, e[W-1:0]);
          check("carry", carry, e[W]);
          $display("[TB] done a/b result sum=%0h carry=%0b expected sum=%0h carry=%0b",
                   sum, carry, e[W-1:0], e[W]);
          last_sum   = e[W-1:0];
          last_carry = e[W];
        end
      end else if (busy) begin
        check("hold_sum", sum, last_sum);
        check("hold_carry", carry, last_carry);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = tsub;
`endif
    start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tsub));
    $display("[TB] start a=%0h b=%0h sub=%0b", ta, tb_v, tsub);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub   = ~tsub;
`endif
  endtask

  task automatic wait_done(output int busy_cycles);
    bit seen;
    int n;
    seen = 0;
    n = 0;
    busy_cycles = 0;
    while (!seen && n < 4 * W) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) busy_cycles++;
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", 4 * W);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int n;
    logic rs;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sum", sum, 0);
    check("rst_carry", carry, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // 0x0F + 0x01: busy for exactly WIDTH cycles, then one-cycle done.
    start_op(8'h0F, 8'h01, 1'b0);
    wait_done(bc);
    check("busy_cycles", bc, W);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);

    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(bc);
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done(bc);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'hA5;
    b = 8'h3C;
    start = 1'b1;
    exp_q.push_back(model(8'hA5, 8'h3C, 1'b0));
    exp_q.push_back(model(8'hA5, 8'h3C, 1'b0));
    $display("[TB] start held a=a5 b=3c (two operations)");
    @(negedge clk);
    wait_done(bc);
    @(negedge clk);
    n = 1;
    while (!done && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("b2b_spacing", n, W + 2);

    // start during RUN is ignored.
    start_op(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'h55;
    b = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    repeat (W + 4) @(negedge clk);
    check("no_extra_done", exp_q.size(), 0);

    // Reset mid-RUN, asserted between clock edges.
    start_op(8'h3C, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", sum, 0);
    check("async_rst_carry", carry, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    exp_q.delete();
    last_sum   = '0;
    last_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check("post_rst_sum", sum, 0);
    start_op(8'h01, 8'h02, 1'b0);
    wait_done(bc);

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h07, 8'h05, 1'b1);
    wait_done(bc);
    start_op(8'h05, 8'h07, 1'b1);
    wait_done(bc);
`endif

    for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      start_op(W'($urandom), W'($urandom), rs);
      wait_done(bc);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
